// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional feature macro used by seg_scan_ctrl: SEG_SCAN_LEADING_ZERO_BLANK_EN.
package seg_scan_pkg;

    // Scan sequencer states; explicit encodings keep the register layout stable.
    typedef enum logic [1:0] {
        StPrime = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    // Active-high a..g patterns, bit 0 = segment a; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // All segments (including dp) dark, before polarity is applied.
    localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-high a..g decoder; polarity is the parent's job.
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared seven-segment display.
// Each digit slot is SCAN_DIV cycles: BLANK_CYCLES dark, then the digit is driven.
// Display data is snapshotted once per frame so mid-frame updates never tear.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to dark leading-zero digits.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 25000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int unsigned CW           = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DRIVE_CYCLES = SCAN_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Idle pin levels after polarity.
    localparam logic [DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    scan_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                load_snap;

    logic [4*DIGITS-1:0] snap_digits_q;
    logic [DIGITS-1:0]   snap_dp_q;
    logic [DIGITS-1:0]   snap_en_q;
    logic [DIGITS-1:0]   snap_lz_q;
    logic [DIGITS-1:0]   lz_mask;

    logic [DIGITS-1:0]   sel_q, sel_d, sel_ah;
    logic [7:0]          seg_q, seg_d, seg_ah;
    logic                fs_q, fs_d;

    logic [3:0]          cur_nib;
    logic [6:0]          hex_segs;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Mark digits i>0 whose nibble and every higher nibble are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            upper_zero = upper_zero & (digits[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Slot sequencer: PRIME once after reset, then BLANK/DRIVE per digit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        load_snap = 1'b0;
        fs_d      = 1'b0;
        unique case (state_q)
            StPrime: begin
                load_snap = 1'b1;
                fs_d      = 1'b1;
                idx_d     = '0;
                cnt_d     = '0;
                state_d   = (BLANK_CYCLES == 0) ? StDrive : StBlank;
            end
            StBlank: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES == 0) ? StDrive : StBlank;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: fresh snapshot and restart at digit 0.
                        idx_d     = '0;
                        load_snap = 1'b1;
                        fs_d      = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StPrime;
                cnt_d   = '0;
            end
        endcase
    end

    assign cur_nib = snap_digits_q[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (cur_nib),
        .segs   (hex_segs)
    );

    // Pin values for the current state; a suppressed digit keeps its select only for dp.
    always_comb begin
        sel_ah = '0;
        seg_ah = SEG_OFF;
        if (state_q == StDrive && snap_en_q[idx_q]) begin
            if (!snap_lz_q[idx_q] || snap_dp_q[idx_q]) begin
                sel_ah[idx_q] = 1'b1;
            end
            seg_ah = {snap_dp_q[idx_q], snap_lz_q[idx_q] ? 7'h00 : hex_segs};
        end
        sel_d = (ACTIVE_LOW != 0) ? ~sel_ah : sel_ah;
        seg_d = (ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
    end

    // Sequencer state and frame snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StPrime;
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_en_q     <= '0;
            snap_lz_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load_snap) begin
                snap_digits_q <= digits;
                snap_dp_q     <= dp;
                snap_en_q     <= digit_en;
                snap_lz_q     <= lz_mask;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= SEL_IDLE;
            seg_q <= SEG_IDLE;
            fs_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            seg_q <= seg_d;
            fs_q  <= fs_d;
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS       = 4;
    localparam int unsigned SCAN_DIV     = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned ACTIVE_LOW   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .ACTIVE_LOW   (ACTIVE_LOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .digit_en    (digit_en),
        .sel         (sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp_sel,
                             input logic [7:0] exp_seg, input logic exp_fs);
        check_eq({tag, ".sel"}, 32'(sel), 32'(exp_sel));
        check_eq({tag, ".seg"}, 32'(seg), 32'(exp_seg));
        check_eq({tag, ".fs"}, 32'(frame_start), 32'(exp_fs));
    endtask

    // Checks one 32-cycle frame starting at the first blank output of slot 0.
    // At the first drive cycle of chg_slot the inputs are replaced (they must not tear).
    task automatic check_frame(input string tag, input logic [3:0][7:0] exp_seg,
                               input logic [3:0] exp_on, input int chg_slot,
                               input logic [15:0] nd, input logic [3:0] ndp,
                               input logic [3:0] nen);
        logic [3:0] s_exp;
        for (int k = 0; k < 4; k++) begin
            s_exp = exp_on[k] ? ~(4'b0001 << k) : 4'hF;
            for (int b = 0; b < 2; b++) begin
                check_out($sformatf("%s.d%0d.blank%0d", tag, k, b), 4'hF, 8'hFF, 1'b0);
                step(1);
            end
            for (int j = 0; j < 6; j++) begin
                if (k == chg_slot && j == 0) begin
                    digits   = nd;
                    dp       = ndp;
                    digit_en = nen;
                end
                check_out($sformatf("%s.d%0d.drv%0d", tag, k, j), s_exp,
                          exp_on[k] ? exp_seg[k] : 8'hFF, (k == 3 && j == 5));
                step(1);
            end
        end
    endtask

    initial begin
        digits   = 16'h1234;
        digit_en = 4'hF;
        dp       = 4'h0;
        rst      = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1);
            check_out($sformatf("reset%0d", i), 4'hF, 8'hFF, 1'b0);
        end

        // PRIME: frame_start on the cycle after release, pins still dark.
        rst = 1'b0;
        step(1);
        check_out("prime", 4'hF, 8'hFF, 1'b1);
        step(1);

        // Basic scan of 1234; digits go to FFFF mid-frame.
        check_frame("scan", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF,
                    1, 16'hFFFF, 4'h0, 4'hF);
        // New snapshot shows F everywhere; enable/dp change mid-frame.
        check_frame("tear", {8'h8E, 8'h8E, 8'h8E, 8'h8E}, 4'hF,
                    1, 16'hFFFF, 4'b0001, 4'b0101);
        // Digits 1 and 3 dark, dp lit on digit 0.
        check_frame("en_dp", {8'hFF, 8'h8E, 8'hFF, 8'h0E}, 4'b0101,
                    1, 16'h1234, 4'h0, 4'hF);

        // Reset during the digit-2 drive of the next frame.
        step(19);
        check_out("pre_rst.d2", 4'b1011, 8'hA4, 1'b0);
        rst = 1'b1;
        step(1);
        check_out("mid_rst0", 4'hF, 8'hFF, 1'b0);
        digits = 16'h0050;
        step(1);
        check_out("mid_rst1", 4'hF, 8'hFF, 1'b0);
        rst = 1'b0;
        step(1);
        check_out("reprime", 4'hF, 8'hFF, 1'b1);
        step(1);

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        check_frame("lz0050", {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b0011,
                    1, 16'h0000, 4'h0, 4'hF);
        check_frame("lz0000", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001,
                    -1, 16'h0000, 4'h0, 4'hF);
`else
        check_frame("lz0050", {8'hC0, 8'hC0, 8'h92, 8'hC0}, 4'hF,
                    1, 16'h0000, 4'h0, 4'hF);
        check_frame("lz0000", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'hF,
                    -1, 16'h0000, 4'h0, 4'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
